// File: rtl/apb_reg_pkg.sv
// Shared types and constants for the APB3 register completer.
// Register indices at the top of the map depend on NUM_REGS, so helpers compute them.
package apb_reg_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam int unsigned CTRL_IDX = 0;
  localparam int unsigned CNT_W    = 4;

  function automatic int unsigned status_idx(input int unsigned num_regs);
    return num_regs - 2;
  endfunction

  function automatic int unsigned xfer_cnt_idx(input int unsigned num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/apb_reg_decode.sv
// Address decode for the register bank: one-hot register select plus error flag.
// Errors cover out-of-range index, misaligned address and writes to read-only words.
module apb_reg_decode
  import apb_reg_pkg::*;
#(
  parameter int ADDRWIDTH = 16,
  parameter int NUM_REGS  = 8
) (
  input  logic [ADDRWIDTH-1:0] paddr,
  input  logic                 pwrite,
  output logic [NUM_REGS-1:0]  reg_sel,
  output logic                 err
);

  localparam int IDX_W      = ADDRWIDTH - 2;
  localparam int STATUS_IDX = int'(status_idx(NUM_REGS));
  localparam int XFER_IDX   = int'(xfer_cnt_idx(NUM_REGS));

  logic [IDX_W-1:0] idx;

  always_comb begin
    idx     = paddr[ADDRWIDTH-1:2];
    reg_sel = '0;
    err     = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) reg_sel[i] = 1'b1;
    end
    if (idx >= IDX_W'(NUM_REGS))       err = 1'b1;
    if (paddr[1:0] != 2'b00)           err = 1'b1;
    if (pwrite && (reg_sel[STATUS_IDX] || reg_sel[XFER_IDX])) err = 1'b1;
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 completer with CTRL/SCRATCH/STATUS/XFER_CNT registers, programmable wait
// states and PSLVERR on bad accesses. All APB activity is qualified by PCLKEN.
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int ADDRWIDTH   = 16,
  parameter int DATAWIDTH   = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic [DATAWIDTH-1:0] STATUS_IN,
  output logic [DATAWIDTH-1:0] CTRL_OUT
);

  localparam int NUM_BANK   = NUM_REGS - 2;
  localparam int STATUS_IDX = int'(status_idx(NUM_REGS));
  localparam int XFER_IDX   = int'(xfer_cnt_idx(NUM_REGS));

  apb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 write_q, write_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic [NUM_BANK-1:0]  sel_q, sel_d;
  logic [DATAWIDTH-1:0] prdata_q, prdata_d;
  logic [DATAWIDTH-1:0] xfer_q, xfer_d;
  logic [DATAWIDTH-1:0] bank_q [NUM_BANK];
  logic [DATAWIDTH-1:0] bank_d [NUM_BANK];

  logic [NUM_REGS-1:0]  dec_sel;
  logic                 dec_err;
  logic [DATAWIDTH-1:0] rd_mux;

  apb_reg_decode #(
    .ADDRWIDTH (ADDRWIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_decode (
    .paddr   (PADDR),
    .pwrite  (PWRITE),
    .reg_sel (dec_sel),
    .err     (dec_err)
  );

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      if (dec_sel[i]) rd_mux = bank_q[i];
    end
    if (dec_sel[STATUS_IDX]) rd_mux = STATUS_IN;
    if (dec_sel[XFER_IDX])   rd_mux = xfer_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    sel_d    = sel_q;
    prdata_d = prdata_q;
    xfer_d   = xfer_q;
    bank_d   = bank_q;
    case (state_q)
      ST_IDLE: begin
        if (PCLKEN && PSEL && !PENABLE) begin
          write_d  = PWRITE;
          wdata_d  = PWDATA;
          err_d    = dec_err;
          sel_d    = dec_sel[NUM_BANK-1:0];
          prdata_d = dec_err ? '0 : rd_mux;
          cnt_d    = CNT_W'(WAIT_STATES);
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (PCLKEN) begin
          if (PSEL && PENABLE) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              if (!err_q) begin
                xfer_d = xfer_q + DATAWIDTH'(1);
                if (write_q) begin
                  for (int i = 0; i < NUM_BANK; i++) begin
                    if (sel_q[i]) bank_d[i] = wdata_q;
                  end
                end
              end
              prdata_d = '0;
              state_d  = ST_IDLE;
            end
          end else begin
            // Master dropped the transfer mid-access: leave without side effects.
            prdata_d = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      sel_q    <= '0;
      prdata_q <= '0;
      xfer_q   <= '0;
      for (int i = 0; i < NUM_BANK; i++) bank_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      sel_q    <= sel_d;
      prdata_q <= prdata_d;
      xfer_q   <= xfer_d;
      for (int i = 0; i < NUM_BANK; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign PREADY   = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign PSLVERR  = PREADY && err_q;
  assign PRDATA   = prdata_q;
  assign CTRL_OUT = bank_q[CTRL_IDX];

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

- APB3 completer holding a small word-addressed register bank with programmable wait states and error response.
- Sits at the APB end of the AHB-to-APB path: it receives PSEL/PENABLE/PADDR/PWRITE/PWDATA and returns PRDATA/PREADY/PSLVERR.
- Exposes a control register to the fabric, samples an external status word, and counts completed transfers.
- Primary bench target for the bridge's APB3 PREADY/PSLVERR handling.

## Interface
- ADDRWIDTH, 16, APB address width.
- DATAWIDTH, 32, APB data width; register width.
- NUM_REGS, 8, word registers; legal 4..16.
- WAIT_STATES, 1, APB cycles PREADY is held low per transfer; legal 0..15.
- HCLK  in  1  clock. One clock; reset is asynchronous and active-low.
- HRESETn  in  1  asynchronous active-low reset.
- PCLKEN  in  1  APB clock enable; all APB sampling and state advance qualified by it.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase.
- PADDR  in  ADDRWIDTH  byte address.
- PWRITE  in  1  1 = write.
- PWDATA  in  DATAWIDTH  write data.
- PRDATA  out  DATAWIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error; valid only while PREADY=1.
- STATUS_IN  in  DATAWIDTH  external status, read-only.
- CTRL_OUT  out  DATAWIDTH  contents of CTRL register.

## Operation
- Register map, word index = PADDR[ADDRWIDTH-1:2]:
  - 0 = CTRL (RW, drives CTRL_OUT).
  - 1..NUM_REGS-3 = SCRATCH (RW).
  - NUM_REGS-2 = STATUS (RO, STATUS_IN).
  - NUM_REGS-1 = XFER_CNT (RO).
- Error conditions, any one of which sets PSLVERR: index >= NUM_REGS; PADDR[1:0] != 0; write to STATUS or XFER_CNT. An errored write changes no register; an errored read returns PRDATA=0.
- FSM states:
  - IDLE: on PCLKEN && PSEL && !PENABLE (setup phase):
    - latch PWRITE and PWDATA;
    - decode the address and latch the error flag;
    - latch read data (STATUS_IN sampled here; XFER_CNT pre-increment value);
    - load wait counter = WAIT_STATES;
    - go to ACCESS.
  - ACCESS, on PCLKEN:
    - PSEL && PENABLE && cnt != 0: cnt decrements.
    - PSEL && PENABLE && cnt == 0: transfer completes. Perform the write if not errored. XFER_CNT += 1 if not errored, wrapping at 2^DATAWIDTH. Clear PRDATA. Go to IDLE.
    - !PSEL, or PSEL && !PENABLE (protocol abort): go to IDLE with no write and no count.
- Without PCLKEN, state, counter and outputs hold.
- Reset:
  - PRDATA=0, PREADY=0, PSLVERR=0, CTRL_OUT=0.
  - All registers and XFER_CNT reset to 0; FSM to IDLE.
  - Reset mid-transfer abandons the transfer with no write.

## Timing
- PREADY = (state==ACCESS && cnt==0). PSLVERR = PREADY && err. Both are decoded from registered state only; no combinational path from APB inputs.
- Access phase lasts WAIT_STATES+1 PCLKEN cycles. WAIT_STATES=0 gives a zero-wait transfer with PREADY high in the first access cycle.
- PRDATA is valid from the HCLK after the setup edge and stable through ACCESS.
- CTRL_OUT and SCRATCH update on the completion edge and are visible the next HCLK.
- Back-to-back: the next setup may occur in the PCLKEN cycle directly after completion; IDLE accepts it immediately.
- A read of a register written in the previous transfer returns the new value.

## Structure
- Package apb_reg_pkg:
  - FSM state encoding (IDLE, ACCESS);
  - register index constants;
  - 4-bit wait-counter width.
- Sub-module apb_reg_decode (combinational): maps index and PWRITE to register select and error flag. The register bank, counter and FSM stay in the top module.

## Test plan
- WAIT_STATES=1, PCLKEN=1: write 0xA5A5_0001 to 0x00 -> PREADY low for 1 access cycle then high, PSLVERR=0, CTRL_OUT=0xA5A5_0001, XFER_CNT=1.
- Read 0x04 after writing 0x1234_5678 -> PRDATA=0x1234_5678. Read 0x18 with STATUS_IN=0xDEAD_BEEF -> PRDATA=0xDEAD_BEEF.
- Write to 0x1C, write to 0x20, read of 0x02 -> each PSLVERR=1 with PREADY=1; no register change; XFER_CNT unchanged; PRDATA=0 on the read.
- PCLKEN high every 3rd HCLK, WAIT_STATES=2 -> PREADY rises on the 3rd PCLKEN access cycle; all outputs hold between enables.
- Six back-to-back zero-wait transfers (WAIT_STATES=0) -> each completes in one access cycle; reading XFER_CNT in the 7th transfer returns 6.
- HRESETn asserted during ACCESS of a write to 0x00 -> CTRL_OUT=0, PREADY=0, FSM in IDLE; the next transfer completes normally.
